// File: rtl/trap_sequencer_if.sv
// Bundle of MEM-stage trap inputs and CSR/pipeline control outputs for trap_sequencer.
// The master drives the inputs, and the slave (the sequencer) drives the outputs.
interface trap_sequencer_if;
  logic        trapseqin_valid;
  logic        trapseqin_is_ecall;
  logic        trapseqin_is_unimp;
  logic        trapseqin_is_mret;
  logic        trapseqin_is_sret;
  logic [31:0] trapseqin_pc;
  logic [31:0] trapseqin_mtvec;
  logic [31:0] trapseqin_mepc;
  logic [31:0] trapseqin_sepc;
  logic [31:0] trapseqin_mstatus;
  logic [31:0] trapseqin_sstatus;
  logic        trapseqout_csr_we;
  logic [11:0] trapseqout_csr_addr;
  logic [31:0] trapseqout_csr_wdata;
  logic        trapseqout_stall;
  logic        trapseqout_flush;
  logic        trapseqout_redirect;
  logic [31:0] trapseqout_redirect_pc;
  logic        trapseqout_busy;

  modport master (
    output trapseqin_valid, trapseqin_is_ecall, trapseqin_is_unimp, trapseqin_is_mret,
           trapseqin_is_sret, trapseqin_pc, trapseqin_mtvec, trapseqin_mepc, trapseqin_sepc,
           trapseqin_mstatus, trapseqin_sstatus,
    input  trapseqout_csr_we, trapseqout_csr_addr, trapseqout_csr_wdata, trapseqout_stall,
           trapseqout_flush, trapseqout_redirect, trapseqout_redirect_pc, trapseqout_busy
  );

  modport slave (
    input  trapseqin_valid, trapseqin_is_ecall, trapseqin_is_unimp, trapseqin_is_mret,
           trapseqin_is_sret, trapseqin_pc, trapseqin_mtvec, trapseqin_mepc, trapseqin_sepc,
           trapseqin_mstatus, trapseqin_sstatus,
    output trapseqout_csr_we, trapseqout_csr_addr, trapseqout_csr_wdata, trapseqout_stall,
           trapseqout_flush, trapseqout_redirect, trapseqout_redirect_pc, trapseqout_busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// This block sequences the CSR writes and the PC redirect for ecall, unimp, mret and sret.
// It writes one CSR per cycle, holds the pipeline stalled until the redirect, and then flushes it.
module trap_sequencer #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2
) (
  input  logic            clk,
  input  logic            rst,
  trap_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWEpc     = 3'd1,
    StWCause   = 3'd2,
    StWStatus  = 3'd3,
    StRedirect = 3'd4
  } state_e;

  typedef enum logic [1:0] {KindEcall, KindUnimp, KindMret, KindSret} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_in;
  logic [31:0] pc_q, mtvec_q, mepc_q, sepc_q, mstatus_q, sstatus_q;
  logic [31:0] trap_status, mret_status, sret_status;
  logic        any_flag, accept, is_trap_q;

  always_comb begin
    kind_in = KindSret;
    if (bus.trapseqin_is_ecall)      kind_in = KindEcall;
    else if (bus.trapseqin_is_unimp) kind_in = KindUnimp;
    else if (bus.trapseqin_is_mret)  kind_in = KindMret;
  end

  assign any_flag = bus.trapseqin_is_ecall | bus.trapseqin_is_unimp |
                    bus.trapseqin_is_mret  | bus.trapseqin_is_sret;
  // Gated by rst so that stall stays low while reset is held, even with a pending accept.
  assign accept   = !rst && (state_q == StIdle) && bus.trapseqin_valid && any_flag;
  assign is_trap_q = (kind_q == KindEcall) || (kind_q == KindUnimp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q    <= KindEcall;
      pc_q      <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      sepc_q    <= '0;
      mstatus_q <= '0;
      sstatus_q <= '0;
    end else if (accept) begin
      kind_q    <= kind_in;
      pc_q      <= bus.trapseqin_pc;
      mtvec_q   <= bus.trapseqin_mtvec;
      mepc_q    <= bus.trapseqin_mepc;
      sepc_q    <= bus.trapseqin_sepc;
      mstatus_q <= bus.trapseqin_mstatus;
      sstatus_q <= bus.trapseqin_sstatus;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (kind_in == KindEcall || kind_in == KindUnimp) ? StWEpc : StWStatus;
        end
      end
      StWEpc:     state_d = StWCause;
      StWCause:   state_d = StWStatus;
      StWStatus:  state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    trap_status        = mstatus_q;
    trap_status[7]     = mstatus_q[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status        = mstatus_q;
    mret_status[3]     = mstatus_q[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b00;
    sret_status        = sstatus_q;
    sret_status[1]     = sstatus_q[5];
    sret_status[5]     = 1'b1;
    sret_status[8]     = 1'b0;
  end

  always_comb begin
    bus.trapseqout_csr_we      = 1'b0;
    bus.trapseqout_csr_addr    = '0;
    bus.trapseqout_csr_wdata   = '0;
    bus.trapseqout_stall       = accept;
    bus.trapseqout_flush       = 1'b0;
    bus.trapseqout_redirect    = 1'b0;
    bus.trapseqout_redirect_pc = '0;
    bus.trapseqout_busy        = (state_q != StIdle);
    case (state_q)
      StWEpc: begin
        bus.trapseqout_csr_we    = 1'b1;
        bus.trapseqout_csr_addr  = 12'h341;
        bus.trapseqout_csr_wdata = pc_q;
        bus.trapseqout_stall     = 1'b1;
      end
      StWCause: begin
        bus.trapseqout_csr_we    = 1'b1;
        bus.trapseqout_csr_addr  = 12'h342;
        bus.trapseqout_csr_wdata = (kind_q == KindEcall) ? CAUSE_ECALL : CAUSE_ILLEGAL;
        bus.trapseqout_stall     = 1'b1;
      end
      StWStatus: begin
        bus.trapseqout_csr_we = 1'b1;
        bus.trapseqout_stall  = 1'b1;
        if (is_trap_q) begin
          bus.trapseqout_csr_addr  = 12'h300;
          bus.trapseqout_csr_wdata = trap_status;
        end else if (kind_q == KindMret) begin
          bus.trapseqout_csr_addr  = 12'h300;
          bus.trapseqout_csr_wdata = mret_status;
        end else begin
          bus.trapseqout_csr_addr  = 12'h100;
          bus.trapseqout_csr_wdata = sret_status;
        end
      end
      StRedirect: begin
        bus.trapseqout_redirect = 1'b1;
        bus.trapseqout_flush    = 1'b1;
        if (is_trap_q)                bus.trapseqout_redirect_pc = {mtvec_q[31:2], 2'b00};
        else if (kind_q == KindMret)  bus.trapseqout_redirect_pc = mepc_q;
        else                          bus.trapseqout_redirect_pc = sepc_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: it runs directed vectors, reset/re-accept corner cases, and
// random traffic compared against a per-cycle expected-output queue model.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  trap_sequencer_if bus();

  trap_sequencer #(
    .CAUSE_ECALL  (32'd11),
    .CAUSE_ILLEGAL(32'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic        busy;
  } out_t;

  typedef struct {
    logic [3:0]  flags;  // {ecall, unimp, mret, sret}
    logic [31:0] pc, mtvec, mepc, sepc, ms, ss;
    int          nw;
    logic [11:0] a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [31:0] rpc;
    int          lat;
  } vec_t;

  out_t mq[$];

  function automatic out_t cur();
    out_t o;
    o.we       = bus.trapseqout_csr_we;
    o.addr     = bus.trapseqout_csr_addr;
    o.wdata    = bus.trapseqout_csr_wdata;
    o.stall    = bus.trapseqout_stall;
    o.flush    = bus.trapseqout_flush;
    o.redirect = bus.trapseqout_redirect;
    o.rpc      = bus.trapseqout_redirect_pc;
    o.busy     = bus.trapseqout_busy;
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got we=%0b addr=%h data=%h stall=%0b flush=%0b redir=%0b rpc=%h busy=%0b; want we=%0b addr=%h data=%h stall=%0b flush=%0b redir=%0b rpc=%h busy=%0b",
               name, $time, act.we, act.addr, act.wdata, act.stall, act.flush, act.redirect,
               act.rpc, act.busy, exp.we, exp.addr, exp.wdata, exp.stall, exp.flush,
               exp.redirect, exp.rpc, exp.busy);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] f, input logic [31:0] pc,
                        input logic [31:0] mtvec, input logic [31:0] mepc,
                        input logic [31:0] sepc, input logic [31:0] ms, input logic [31:0] ss);
    bus.trapseqin_valid    = v;
    bus.trapseqin_is_ecall = f[3];
    bus.trapseqin_is_unimp = f[2];
    bus.trapseqin_is_mret  = f[1];
    bus.trapseqin_is_sret  = f[0];
    bus.trapseqin_pc       = pc;
    bus.trapseqin_mtvec    = mtvec;
    bus.trapseqin_mepc     = mepc;
    bus.trapseqin_sepc     = sepc;
    bus.trapseqin_mstatus  = ms;
    bus.trapseqin_sstatus  = ss;
  endtask

  function automatic out_t wr(input logic [11:0] a, input logic [31:0] d);
    out_t o = '0;
    o.we = 1'b1; o.addr = a; o.wdata = d; o.stall = 1'b1; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t rd(input logic [31:0] pc);
    out_t o = '0;
    o.redirect = 1'b1; o.flush = 1'b1; o.rpc = pc; o.busy = 1'b1;
    return o;
  endfunction

  // Reference model: on accept, queue the exact output of every following cycle.
  function automatic void build_seq(input logic [3:0] f, input logic [31:0] pc,
                                    input logic [31:0] mtvec, input logic [31:0] mepc,
                                    input logic [31:0] sepc, input logic [31:0] ms,
                                    input logic [31:0] ss);
    if (f[3] || f[2]) begin
      mq.push_back(wr(12'h341, pc));
      mq.push_back(wr(12'h342, f[3] ? 32'd11 : 32'd2));
      mq.push_back(wr(12'h300, (ms & ~32'h1888) | (((ms >> 3) & 32'd1) << 7) | 32'h1800));
      mq.push_back(rd(mtvec & ~32'd3));
    end else if (f[1]) begin
      mq.push_back(wr(12'h300, (ms & ~32'h1888) | (((ms >> 7) & 32'd1) << 3) | 32'h80));
      mq.push_back(rd(mepc));
    end else begin
      mq.push_back(wr(12'h100, (ss & ~32'h122) | (((ss >> 5) & 32'd1) << 1) | 32'h20));
      mq.push_back(rd(sepc));
    end
  endfunction

  vec_t vt[5];
  out_t exp_o;

  initial begin
    vt[0] = '{4'b1000, 32'h80000010, 32'h80000101, 32'h0, 32'h0, 32'h00000008, 32'h0,
              3, 12'h341, 12'h342, 12'h300, 32'h80000010, 32'd11, 32'h00001880,
              32'h80000100, 4};
    vt[1] = '{4'b0100, 32'h80000020, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 32'h0,
              3, 12'h341, 12'h342, 12'h300, 32'h80000020, 32'd2, 32'h00001800,
              32'h80000000, 4};
    vt[2] = '{4'b0010, 32'h0, 32'h0, 32'h80000014, 32'h0, 32'h00001880, 32'h0,
              1, 12'h300, 12'h0, 12'h0, 32'h00000088, 32'h0, 32'h0, 32'h80000014, 2};
    vt[3] = '{4'b1010, 32'h80000010, 32'h80000101, 32'h80000200, 32'h0, 32'h00000008, 32'h0,
              3, 12'h341, 12'h342, 12'h300, 32'h80000010, 32'd11, 32'h00001880,
              32'h80000100, 4};
    vt[4] = '{4'b0001, 32'h0, 32'h0, 32'h0, 32'h80200000, 32'h0, 32'h00000120,
              1, 12'h100, 12'h0, 12'h0, 32'h00000022, 32'h0, 32'h0, 32'h80200000, 2};

    // Reset held with an accepting input must keep every output at zero.
    rst = 1'b1;
    set_in(1'b1, 4'b1000, 32'h1234, 32'h100, 32'h200, 32'h300, 32'h8, 32'h20);
    #1;
    chk("reset_outputs", cur(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 4'b1111, 32'h1234, 32'h100, 32'h200, 32'h300, 32'h8, 32'h20);
    #1;
    chk("flags_without_valid", cur(), '0);
    @(negedge clk);
    #1;
    chk("still_idle", cur(), '0);

    // Directed vectors; the inputs are scrambled after accept to show they are captured.
    foreach (vt[k]) begin
      int nw, lat;
      logic [31:0] got_rpc, ea, ed;
      @(negedge clk);
      set_in(1'b1, vt[k].flags, vt[k].pc, vt[k].mtvec, vt[k].mepc, vt[k].sepc, vt[k].ms,
             vt[k].ss);
      #1;
      chk_val($sformatf("v%0d_accept_stall", k), {31'd0, bus.trapseqout_stall}, 32'd1);
      nw = 0; lat = -1; got_rpc = '0;
      @(negedge clk);
      set_in(1'b0, 4'b0000, ~vt[k].pc, ~vt[k].mtvec, ~vt[k].mepc, ~vt[k].sepc, ~vt[k].ms,
             ~vt[k].ss);
      for (int c = 1; c <= 6; c++) begin
        #1;
        if (bus.trapseqout_csr_we) begin
          ea = (nw == 0) ? {20'd0, vt[k].a0} : (nw == 1) ? {20'd0, vt[k].a1} : {20'd0, vt[k].a2};
          ed = (nw == 0) ? vt[k].d0 : (nw == 1) ? vt[k].d1 : vt[k].d2;
          chk_val($sformatf("v%0d_w%0d_addr", k, nw), {20'd0, bus.trapseqout_csr_addr}, ea);
          chk_val($sformatf("v%0d_w%0d_data", k, nw), bus.trapseqout_csr_wdata, ed);
          nw++;
        end
        if (bus.trapseqout_redirect && lat < 0) begin
          lat = c;
          got_rpc = bus.trapseqout_redirect_pc;
        end
        @(negedge clk);
      end
      chk_val($sformatf("v%0d_nwrites", k), nw, vt[k].nw);
      chk_val($sformatf("v%0d_latency", k), lat, vt[k].lat);
      chk_val($sformatf("v%0d_redirect_pc", k), got_rpc, vt[k].rpc);
    end

    // An ecall held through REDIRECT is ignored there and re-accepted on the next IDLE cycle.
    @(negedge clk);
    set_in(1'b1, 4'b1000, 32'h40, 32'h80000007, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    exp_o = '0; exp_o.stall = 1'b1;
    chk("hold_accept", cur(), exp_o);
    repeat (4) @(negedge clk);
    #1;
    chk("hold_redirect", cur(), rd(32'h80000004));
    @(negedge clk);
    #1;
    chk("hold_reaccept", cur(), exp_o);
    @(negedge clk);
    set_in(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);

    // Reset during W_CAUSE aborts the sequence.
    set_in(1'b1, 4'b1000, 32'h80000010, 32'h80000100, 32'h0, 32'h0, 32'h8, 32'h0);
    @(negedge clk);
    set_in(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("abort_in_cause", cur(), wr(12'h342, 32'd11));
    rst = 1'b1;
    #1;
    chk("abort_reset_zero", cur(), '0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk_val("abort_quiet", {30'd0, bus.trapseqout_csr_we, bus.trapseqout_redirect}, 32'd0);
      @(negedge clk);
    end

    // Random traffic against the queue model, with occasional mid-flight resets.
    mq.delete();
    for (int i = 0; i < 3000; i++) begin
      logic        v;
      logic [3:0]  f;
      logic [31:0] pc, mt, me, se, ms, ss;
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_reset", cur(), '0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
      end
      v  = ($urandom_range(0, 2) == 0);
      f  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      pc = $urandom; mt = $urandom; me = $urandom; se = $urandom;
      ms = $urandom; ss = $urandom;
      set_in(v, f, pc, mt, me, se, ms, ss);
      #1;
      if (mq.size() > 0) begin
        exp_o = mq.pop_front();
      end else begin
        exp_o = '0;
        if (v && (f != 4'b0000)) begin
          exp_o.stall = 1'b1;
          build_seq(f, pc, mt, me, se, ms, ss);
        end
      end
      chk("rand_cycle", cur(), exp_o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CAUSE_ECALL, 32'd11, mcause value for ecall; CAUSE_ILLEGAL, 32'd2, mcause value for unimp.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trapseqin_valid  in  1  MEM-stage instruction valid.
- trapseqin_is_ecall / trapseqin_is_unimp / trapseqin_is_mret / trapseqin_is_sret  in  1 each  decoded MEM-stage system instruction.
- trapseqin_pc  in  32  MEM-stage instruction PC.
- trapseqin_mtvec / trapseqin_mepc / trapseqin_sepc  in  32 each  current CSR values.
- trapseqin_mstatus / trapseqin_sstatus  in  32 each  current CSR values.
- trapseqout_csr_we  out  1  CSR write strobe.
- trapseqout_csr_addr  out  12  CSR write address.
- trapseqout_csr_wdata  out  32  CSR write data.
- trapseqout_stall  out  1  freeze IF..MEM.
- trapseqout_flush  out  1  flush IF..MEM.
- trapseqout_redirect  out  1  PC redirect pulse.
- trapseqout_redirect_pc  out  32  redirect target.
- trapseqout_busy  out  1  sequence in progress.

Function
REQ-003 The FSM SHALL have states IDLE, W_EPC, W_CAUSE, W_STATUS and REDIRECT, encoded in 3 bits.
REQ-004 "Accept" SHALL mean: state is IDLE, trapseqin_valid=1, and at least one is_* flag is 1.
REQ-005 When more than one flag is set, the priority SHALL be ecall > unimp > mret > sret; only the winning kind SHALL be captured.
REQ-006 On accept, the block SHALL register the kind, pc, mtvec, mepc, sepc, mstatus and sstatus; later input changes SHALL have no effect on the sequence.
REQ-007 Trap kinds (ecall, unimp) SHALL follow IDLE -> W_EPC -> W_CAUSE -> W_STATUS -> REDIRECT -> IDLE, advancing one state per cycle.
REQ-008 Return kinds (mret, sret) SHALL follow IDLE -> W_STATUS -> REDIRECT -> IDLE.
REQ-009 The CSR write port SHALL drive exactly one write per W_* cycle and no writes in any other state, as follows:
- W_EPC: addr 0x341, data = captured pc.
- W_CAUSE: addr 0x342, data = CAUSE_ECALL or CAUSE_ILLEGAL.
- W_STATUS for a trap: addr 0x300; data = captured mstatus with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11.
- W_STATUS for mret: addr 0x300; data = captured mstatus with bit3 = old bit7, bit7 = 1, bits12:11 = 2'b00.
- W_STATUS for sret: addr 0x100; data = captured sstatus with bit1 (SIE) = old bit5, bit5 (SPIE) = 1, bit8 (SPP) = 0.
REQ-010 All bits not named in REQ-009 SHALL pass through unchanged.
REQ-011 When csr_we=0, csr_addr and csr_wdata SHALL be 0.
REQ-012 In REDIRECT, the block SHALL hold redirect=1 and flush=1 for exactly one cycle.
REQ-013 redirect_pc SHALL be {captured mtvec[31:2], 2'b00} for traps, captured mepc for mret, and captured sepc for sret; it SHALL be 0 when redirect=0.
REQ-014 stall SHALL be 1 combinationally in the accept cycle and in every W_* state, and 0 in IDLE (without accept) and in REDIRECT.
REQ-015 busy SHALL be 1 exactly when state != IDLE.
REQ-016 trapseqin_valid and all flags SHALL be ignored in every non-IDLE state, including REDIRECT.
REQ-017 A new accept SHALL be possible in the first IDLE cycle after REDIRECT.
REQ-018 A trap sequence SHALL have 4-cycle latency from accept to redirect; a return sequence SHALL have 2-cycle latency.
REQ-019 Flags set while valid=0 SHALL cause no action.

Reset
REQ-020 While rst=1, asynchronously: state SHALL be IDLE, all captured registers SHALL be 0, and every output SHALL be 0.
REQ-021 A reset asserted mid-sequence SHALL abort the sequence; no further CSR writes or redirect from that sequence SHALL follow reset release.

Verification
REQ-022 Ecall: valid, is_ecall, pc=0x80000010, mtvec=0x80000101, mstatus=0x00000008 -> writes (0x341, 0x80000010), then (0x342, 11), then (0x300, 0x00001880); then redirect to 0x80000100 with flush=1; stall high for 4 cycles.
REQ-023 Unimp with mstatus=0 -> second write is (0x342, 2); third write is (0x300, 0x00001800).
REQ-024 mret: mepc=0x80000014, mstatus=0x00001880 -> single write (0x300, 0x00000088); redirect to 0x80000014 two cycles after accept.
REQ-025 is_ecall and is_mret both set -> full trap sequence; no mstatus restore.
REQ-026 Sret: sepc=0x80200000, sstatus=0x00000120 -> write (0x100, 0x00000022); redirect to 0x80200000.
REQ-027 rst pulsed during W_CAUSE -> all outputs 0 immediately; no W_STATUS write and no redirect after release; inputs changed during a sequence do not alter written data; an ecall held through REDIRECT is re-accepted only in the following IDLE cycle.
